ste_serial_rx: RTL and testbench
================================

Name: ste_serial_rx

Overview:
- Serial-to-parallel receiver for the bitstream produced by the team's generic shift register (parallel load, serial out MSB first).
- Collects DATA_W strobed bits into a word, aligned by a frame-start marker.
- Presents each complete word on a valid/ready parallel interface.
- Reports framing errors and overflow as sticky flags.

Parameters:
- DATA_W, 16, word width in bits; legal range 2 to 64.
- MSB_FIRST, 1:
  - 1: the first received bit lands in dout_o[DATA_W-1].
  - 0: the first received bit lands in dout_o[0].

Ports:
- clk  input  1  system clock, rising edge.
- reset_ni  input  1  asynchronous active-low reset.
- sdat_i  input  1  serial data bit.
- sval_i  input  1  bit strobe; sdat_i is sampled only when sval_i=1.
- sframe_i  input  1  frame start; qualified by sval_i, marks the first bit of a word.
- clr_i  input  1  synchronous clear.
- dout_o  output  DATA_W  received word.
- dout_valid_o  output  1  dout_o holds an unconsumed word.
- dout_ready_i  input  1  consumer accepts the word.
- busy_o  output  1  a word is partially received.
- frame_err_o  output  1  sticky: a frame start arrived mid-word.
- ovf_o  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (async, reset_ni=0):
  - FSM=IDLE; shift register, bit counter and dout_o are all 0.
  - dout_valid_o, busy_o, frame_err_o and ovf_o are all 0.
- clr_i has highest priority. It gives the same result as reset, one cycle later, and overrides every other event in that cycle.
- Bit counter width is $clog2(DATA_W)+1. It counts bits received in the current word.
- Shift direction:
  - MSB_FIRST=1: shift = {shift[DATA_W-2:0], sdat_i}.
  - MSB_FIRST=0: shift = {sdat_i, shift[DATA_W-1:1]}.
- FSM state IDLE:
  - sval_i=1 and sframe_i=0: the bit is discarded and there is no state change.
  - sval_i=1 and sframe_i=1: the bit is captured, count=1, next state is SHIFT.
- FSM state SHIFT (busy_o=1):
  - Each sval_i=1 with sframe_i=0 shifts in the bit and increments count.
  - sval_i=0: everything holds; strobes may have arbitrary gaps.
  - sval_i=1 with sframe_i=1 is a mid-word frame start:
    - frame_err_o is set to 1.
    - The partial word is discarded.
    - The current bit is taken as bit 1 of a new word (count=1) and the FSM stays in SHIFT.
  - Word complete is the strobe that brings count to DATA_W. On that strobe:
    - The full word, including the current bit, is transferred to the output register.
    - count is reset to 0 and the FSM goes to IDLE.
    - A sframe_i on the next strobe is legal.
- Output handshake:
  - dout_valid_o rises on the clock edge that completes the word, so the latency is 1 cycle after the last strobe.
  - dout_o and dout_valid_o stay stable until a cycle in which dout_valid_o=1 and dout_ready_i=1. dout_valid_o then falls on the following edge.
  - dout_o keeps its last value after it is accepted.
- Simultaneous events:
  - Word complete and accept in the same cycle: dout_o loads the new word and dout_valid_o stays 1.
  - Word complete while dout_valid_o=1 and dout_ready_i=0:
    - The new word is dropped and ovf_o is set to 1.
    - dout_o keeps the old word.
    - The FSM still returns to IDLE.
  - Word complete together with a sframe_i on the same strobe: this is only possible when DATA_W is reached through count=1. It is not legal for DATA_W>=2, so no handling is needed.
- Sticky flags: frame_err_o and ovf_o are cleared only by reset or clr_i.
- Reset asserted mid-word: all state is lost immediately. After release the block needs a new sframe_i before it accepts any bits.

Test Plan:
1. DATA_W=16, MSB_FIRST=1: send 0xA5C3 MSB first, sval_i=1 every cycle, sframe_i on bit 1, dout_ready_i=0.
   -> dout_valid_o=1 one cycle after the 16th strobe, dout_o=0xA5C3, busy_o=0.
   -> Then raise dout_ready_i=1: dout_valid_o=0 on the next edge.
2. Same word, sval_i every 3rd cycle with sdat_i toggling between strobes.
   -> dout_o=0xA5C3, so non-strobed values are ignored.
   -> 5 strobes without sframe_i beforehand produce no capture.
3. dout_ready_i=0, send 0x1111 then 0x2222 back to back.
   -> dout_o=0x1111 and dout_valid_o=1.
   -> ovf_o=1 one cycle after the last bit of 0x2222.
   -> clr_i clears ovf_o and dout_valid_o.
4. Send 0x1111. Hold dout_ready_i=1 exactly in the cycle of 0x2222's 16th strobe.
   -> dout_valid_o stays 1, dout_o=0x2222, ovf_o=0.
5. Send 7 bits, then start a new frame with 0x1234.
   -> frame_err_o=1, dout_o=0x1234, no spurious dout_valid_o.
   -> With MSB_FIRST=0 and 0x1234 sent LSB first: dout_o=0x1234.
6. Assert reset_ni=0 asynchronously after bit 9.
   -> All outputs are 0 before the next clock edge.
   -> After release, 16 strobes without sframe_i give no dout_valid_o.

Source files
------------

// File: rtl/ste_serial_rx.sv
// rtl/ste_serial_rx.sv - framed serial-to-parallel receiver with valid/ready output
// Sticky frame-error and overflow flags; clr_i behaves like a synchronous reset.
module ste_serial_rx #(
  parameter int DATA_W    = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_ni,
  input  logic              sdat_i,
  input  logic              sval_i,
  input  logic              sframe_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_valid_o,
  input  logic              dout_ready_i,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic              ovf_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d, dout_q, dout_d;
  logic [DATA_W-1:0]   shifted, first_bit;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                valid_q, valid_d, ferr_q, ferr_d, ovf_q, ovf_d;

  // A frame start loads its bit into an otherwise empty word.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted   = {shift_q[DATA_W-2:0], sdat_i};
      assign first_bit = {{(DATA_W-1){1'b0}}, sdat_i};
    end else begin : g_lsb
      assign shifted   = {sdat_i, shift_q[DATA_W-1:1]};
      assign first_bit = {sdat_i, {(DATA_W-1){1'b0}}};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovf_d   = ovf_q;

    if (valid_q && dout_ready_i) valid_d = 1'b0;

    if (sval_i) begin
      case (state_q)
        IDLE: begin
          if (sframe_i) begin
            shift_d = first_bit;
            count_d = CNT_W'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (sframe_i) begin
            ferr_d  = 1'b1;
            shift_d = first_bit;
            count_d = CNT_W'(1);
          end else if (count_q == CNT_W'(DATA_W - 1)) begin
            shift_d = shifted;
            count_d = '0;
            state_d = IDLE;
            // An unconsumed word blocks the new one unless it leaves this cycle.
            if (!valid_q || dout_ready_i) begin
              dout_d  = shifted;
              valid_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            shift_d = shifted;
            count_d = count_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (clr_i) begin
      state_d = IDLE;
      shift_d = '0;
      count_d = '0;
      dout_d  = '0;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign busy_o       = (state_q == SHIFT);
  assign frame_err_o  = ferr_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_ste_serial_rx.sv
// tb/tb_ste_serial_rx.sv - bench for ste_serial_rx, MSB-first and LSB-first instances
// A bit-queue model predicts every output; directed cases pin literal values.
module tb_ste_serial_rx;

  logic        clk = 1'b0;
  logic        reset_ni, sdat_i, sval_i, sframe_i, clr_i, dout_ready_i;
  logic [15:0] dout_a, dout_b;
  logic        valid_a, valid_b, busy_a, busy_b, ferr_a, ferr_b, ovf_a, ovf_b;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  bit          mq[$];
  bit          m_active = 1'b0, m_valid = 1'b0, m_ferr = 1'b0, m_ovf = 1'b0, m_nv;
  logic [15:0] m_dout_m = '0, m_dout_l = '0, m_wm, m_wl;

  always #5 clk = ~clk;

  ste_serial_rx #(.DATA_W(16), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset_ni(reset_ni), .sdat_i(sdat_i), .sval_i(sval_i),
    .sframe_i(sframe_i), .clr_i(clr_i), .dout_o(dout_a), .dout_valid_o(valid_a),
    .dout_ready_i(dout_ready_i), .busy_o(busy_a), .frame_err_o(ferr_a), .ovf_o(ovf_a)
  );

  ste_serial_rx #(.DATA_W(16), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset_ni(reset_ni), .sdat_i(sdat_i), .sval_i(sval_i),
    .sframe_i(sframe_i), .clr_i(clr_i), .dout_o(dout_b), .dout_valid_o(valid_b),
    .dout_ready_i(dout_ready_i), .busy_o(busy_b), .frame_err_o(ferr_b), .ovf_o(ovf_b)
  );

  // Model: the word is the list of bits since the last frame start.
  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni || clr_i) begin
      mq.delete();
      m_active = 1'b0;
      m_valid  = 1'b0;
      m_ferr   = 1'b0;
      m_ovf    = 1'b0;
      m_dout_m = '0;
      m_dout_l = '0;
    end else begin
      m_nv = m_valid && !dout_ready_i;
      if (sval_i) begin
        if (sframe_i) begin
          if (m_active) m_ferr = 1'b1;
          mq.delete();
          mq.push_back(sdat_i);
          m_active = 1'b1;
        end else if (m_active) begin
          mq.push_back(sdat_i);
          if (mq.size() == 16) begin
            m_wm = '0;
            m_wl = '0;
            for (int i = 0; i < 16; i++) begin
              if (mq[i]) begin
                m_wm = m_wm | (16'd1 << (15 - i));
                m_wl = m_wl | (16'd1 << i);
              end
            end
            if (!m_valid || dout_ready_i) begin
              m_dout_m = m_wm;
              m_dout_l = m_wl;
              m_nv     = 1'b1;
            end else begin
              m_ovf = 1'b1;
            end
            mq.delete();
            m_active = 1'b0;
          end
        end
      end
      m_valid = m_nv;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("dout_a",  dout_a,  m_dout_m);
      check("dout_b",  dout_b,  m_dout_l);
      check("valid_a", valid_a, m_valid);
      check("valid_b", valid_b, m_valid);
      check("busy_a",  busy_a,  m_active);
      check("busy_b",  busy_b,  m_active);
      check("ferr_a",  ferr_a,  m_ferr);
      check("ferr_b",  ferr_b,  m_ferr);
      check("ovf_a",   ovf_a,   m_ovf);
      check("ovf_b",   ovf_b,   m_ovf);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr;
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  task automatic drain;
    dout_ready_i = 1'b1;
    tick();
    dout_ready_i = 1'b0;
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      sdat_i   = 1'($urandom);
      sval_i   = 1'b1;
      sframe_i = (i == 0);
      tick();
    end
    sval_i   = 1'b0;
    sframe_i = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit lsb, input int gap, input bit ready_last);
    for (int i = 0; i < 16; i++) begin
      sdat_i   = lsb ? w[i] : w[15-i];
      sval_i   = 1'b1;
      sframe_i = (i == 0);
      if (ready_last) dout_ready_i = (i == 15);
      tick();
      sval_i   = 1'b0;
      sframe_i = 1'b0;
      for (int g = 0; g < gap; g++) begin
        sdat_i = ~sdat_i;
        tick();
      end
    end
    if (ready_last) dout_ready_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout_a"}, dout_a, 16'h0);
    check({tag, "_dout_b"}, dout_b, 16'h0);
    check({tag, "_flags_a"}, {valid_a, busy_a, ferr_a, ovf_a}, 4'b0000);
    check({tag, "_flags_b"}, {valid_b, busy_b, ferr_b, ovf_b}, 4'b0000);
  endtask

  initial begin
    reset_ni = 1'b0; sdat_i = 1'b0; sval_i = 1'b0; sframe_i = 1'b0;
    clr_i = 1'b0; dout_ready_i = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    reset_ni = 1'b1;
    cmp_en   = 1'b1;
    tick();

    // 1: contiguous strobes, held output
    send_word(16'hA5C3, 1'b0, 0, 1'b0);
    check("t1_dout", dout_a, 16'hA5C3);
    check("t1_model_pin", m_dout_m, 16'hA5C3);
    check("t1_valid", valid_a, 1'b1);
    check("t1_busy", busy_a, 1'b0);
    drain();
    check("t1_accept", valid_a, 1'b0);
    check("t1_dout_kept", dout_a, 16'hA5C3);

    // 2: gapped strobes with toggling data in the gaps, then unframed strobes
    do_clr();
    send_word(16'hA5C3, 1'b0, 2, 1'b0);
    check("t2_dout", dout_a, 16'hA5C3);
    drain();
    for (int i = 0; i < 5; i++) begin
      sdat_i = 1'($urandom); sval_i = 1'b1; sframe_i = 1'b0;
      tick();
    end
    sval_i = 1'b0;
    check("t2_no_capture", {busy_a, valid_a}, 2'b00);

    // 3: overflow
    do_clr();
    send_word(16'h1111, 1'b0, 0, 1'b0);
    send_word(16'h2222, 1'b0, 0, 1'b0);
    check("t3_dout", dout_a, 16'h1111);
    check("t3_valid_ovf", {valid_a, ovf_a}, 2'b11);
    do_clr();
    check("t3_clr", {valid_a, ovf_a}, 2'b00);

    // 4: completion and accept in the same cycle
    send_word(16'h1111, 1'b0, 0, 1'b0);
    send_word(16'h2222, 1'b0, 0, 1'b1);
    check("t4_dout", dout_a, 16'h2222);
    check("t4_valid_ovf", {valid_a, ovf_a}, 2'b10);
    drain();

    // 5: mid-word frame start, both bit orders
    do_clr();
    send_bits(7);
    send_word(16'h1234, 1'b0, 0, 1'b0);
    check("t5_ferr", ferr_a, 1'b1);
    check("t5_dout", dout_a, 16'h1234);
    do_clr();
    send_bits(7);
    send_word(16'h1234, 1'b1, 0, 1'b0);
    check("t5_dout_lsb", dout_b, 16'h1234);
    check("t5_ferr_lsb", ferr_b, 1'b1);

    // 6: async reset mid-word
    do_clr();
    send_bits(9);
    #2;
    reset_ni = 1'b0;
    #1;
    check_all_zero("t6_async");
    tick();
    reset_ni = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sdat_i = 1'($urandom); sval_i = 1'b1; sframe_i = 1'b0;
      tick();
    end
    sval_i = 1'b0;
    tick();
    check("t6_no_word", {valid_a, busy_a}, 2'b00);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      sval_i       = ($urandom_range(0, 9) < 6);
      sframe_i     = ($urandom_range(0, 19) == 0);
      sdat_i       = 1'($urandom);
      dout_ready_i = 1'($urandom);
      clr_i        = ($urandom_range(0, 299) == 0);
      tick();
    end
    sval_i = 1'b0; sframe_i = 1'b0; clr_i = 1'b0; dout_ready_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
